// File: rtl/traffic_light_sequencer.sv
// Two-road intersection phase sequencer with pedestrian walk insertion.
// Advances on tick strobes and drives registered lamp and walk outputs.
module traffic_light_sequencer #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 5,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 ped_req,
  output logic [2:0]           ns_light,
  output logic [2:0]           ew_light,
  output logic                 walk,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] phase_cnt,
  output logic                 ped_pending
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    WALK      = 3'd6
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_WIDTH-1:0] G_LAST =
    CNT_WIDTH'(GREEN_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST =
    CNT_WIDTH'(YELLOW_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] R_LAST =
    CNT_WIDTH'(ALLRED_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] W_LAST =
    CNT_WIDTH'(WALK_TICKS - 1);

  phase_t               state;
  phase_t               state_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic                 enter_walk;
  logic [2:0]           ns_nx;
  logic [2:0]           ew_nx;
  logic                 walk_nx;

  assign phase = state;

  always_comb begin
    last_cnt = '0;
    unique case (state)
      NS_GREEN, EW_GREEN:   last_cnt = G_LAST;
      NS_YELLOW, EW_YELLOW: last_cnt = Y_LAST;
      ALL_RED_A, ALL_RED_B: last_cnt = R_LAST;
      WALK:                 last_cnt = W_LAST;
      default:              last_cnt = '0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = phase_cnt;
    enter_walk = 1'b0;
    if (state == 3'd7) begin
      // Corrupted encoding: recover through an all-red phase.
      state_nx = ALL_RED_B;
      cnt_nx   = '0;
    end else if (tick) begin
      if (phase_cnt == last_cnt) begin
        cnt_nx = '0;
        unique case (state)
          NS_GREEN:  state_nx = NS_YELLOW;
          NS_YELLOW: state_nx = ALL_RED_A;
          ALL_RED_A: state_nx = EW_GREEN;
          EW_GREEN:  state_nx = EW_YELLOW;
          EW_YELLOW: state_nx = ALL_RED_B;
          ALL_RED_B: begin
            if (ped_pending) begin
              state_nx   = WALK;
              enter_walk = 1'b1;
            end else begin
              state_nx = NS_GREEN;
            end
          end
          WALK:      state_nx = NS_GREEN;
          default:   state_nx = ALL_RED_B;
        endcase
      end else begin
        cnt_nx = phase_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ns_nx   = RED;
    ew_nx   = RED;
    walk_nx = 1'b0;
    unique case (state_nx)
      NS_GREEN:  ns_nx = GRN;
      NS_YELLOW: ns_nx = YEL;
      EW_GREEN:  ew_nx = GRN;
      EW_YELLOW: ew_nx = YEL;
      WALK:      walk_nx = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALL_RED_B;
      phase_cnt   <= '0;
      ped_pending <= 1'b0;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
    end else begin
      state       <= state_nx;
      phase_cnt   <= cnt_nx;
      ped_pending <= (ped_pending & ~enter_walk) | ped_req;
      ns_light    <= ns_nx;
      ew_light    <= ew_nx;
      walk        <= walk_nx;
    end
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer: stimulus queues
// expected states, a negedge monitor pops and compares them.
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic [7:0] phase_cnt;
  logic       ped_pending;

  traffic_light_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .phase       (phase),
    .phase_cnt   (phase_cnt),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ph;
    int    cnt;
    logic  ped;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  bit   armed = 0;

  int dur[7] = '{8, 3, 1, 8, 3, 1, 5};
  int nxt[7] = '{1, 2, 3, 4, 5, 0, 0};

  int   m_ph = 5;
  int   m_cnt = 0;
  logic m_ped = 1'b0;

  function automatic logic [2:0] lamp_ns(int ph);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_ew(int ph);
    case (ph)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [2:0] ens;
      logic [2:0] eew;
      e   = q.pop_front();
      ens = lamp_ns(e.ph);
      eew = lamp_ew(e.ph);
      checks++;
      if (phase === 3'(e.ph) && phase_cnt === 8'(e.cnt) &&
          ped_pending === e.ped && ns_light === ens &&
          ew_light === eew && walk === (e.ph == 6))
        passed++;
      else
        $display("FAIL %s: got ph=%0d cnt=%0d ped=%b ns=%b ew=%b walk=%b, want ph=%0d cnt=%0d ped=%b ns=%b ew=%b walk=%b",
                 e.name, phase, phase_cnt, ped_pending, ns_light,
                 ew_light, walk, e.ph, e.cnt, e.ped, ens, eew,
                 e.ph == 6);
    end
    if (armed) begin
      checks++;
      if (ns_light != 3'b100 && ew_light != 3'b100)
        $display("FAIL conflict: ns=%b ew=%b want one road red",
                 ns_light, ew_light);
      else
        passed++;
    end
  end

  task automatic predict(input logic t, input logic p,
                         input logic r);
    logic enter;
    enter = 1'b0;
    if (r) begin
      m_ph  = 5;
      m_cnt = 0;
      m_ped = 1'b0;
    end else begin
      if (t) begin
        if (m_cnt == dur[m_ph] - 1) begin
          m_cnt = 0;
          if (m_ph == 5 && m_ped) begin
            m_ph  = 6;
            enter = 1'b1;
          end else begin
            m_ph = nxt[m_ph];
          end
        end else begin
          m_cnt++;
        end
      end
      m_ped = (m_ped & ~enter) | p;
    end
  endtask

  task automatic cyc(input logic t, input logic p, input logic r);
    exp_t e;
    tick    = t;
    ped_req = p;
    reset   = r;
    @(posedge clk);
    #1;
    predict(t, p, r);
    tick    = 1'b0;
    ped_req = 1'b0;
    reset   = 1'b0;
    e = '{name: "pred", ph: m_ph, cnt: m_cnt, ped: m_ped};
    q.push_back(e);
  endtask

  task automatic hand(input string n, input int ph, input int cnt,
                      input logic ped);
    exp_t e;
    e = '{name: n, ph: ph, cnt: cnt, ped: ped};
    q.push_back(e);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset then idle, tick every 4 clocks.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    hand("reset", 5, 0, 1'b0);
    armed = 1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    hand("idle_hold", 5, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    hand("first_tick", 0, 0, 1'b0);

    // Full rotation with no request.
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      case (i)
        8:  hand("rot_ns_yel", 1, 0, 1'b0);
        11: hand("rot_red_a", 2, 0, 1'b0);
        12: hand("rot_ew_grn", 3, 0, 1'b0);
        20: hand("rot_ew_yel", 4, 0, 1'b0);
        23: hand("rot_red_b", 5, 0, 1'b0);
        24: hand("rot_wrap", 0, 0, 1'b0);
        default: ;
      endcase
    end

    // Pedestrian request during EW_GREEN.
    ticks(12, 1);
    cyc(1'b0, 1'b1, 1'b0);
    hand("ped_latch", 3, 0, 1'b1);
    ticks(11, 0);
    hand("ped_red_b", 5, 0, 1'b1);
    ticks(1, 0);
    hand("walk_entry", 6, 0, 1'b0);

    // Request during WALK stays latched.
    ticks(2, 2);
    cyc(1'b0, 1'b1, 1'b0);
    hand("walk_req", 6, 2, 1'b1);
    ticks(3, 0);
    hand("walk_exit", 0, 0, 1'b1);
    ticks(23, 0);
    hand("second_red_b", 5, 0, 1'b1);
    // Request on the enter_walk edge survives into WALK.
    cyc(1'b1, 1'b1, 1'b0);
    hand("enter_walk_req", 6, 0, 1'b1);
    ticks(5, 1);
    hand("walk_done", 0, 0, 1'b1);
    ticks(24, 0);
    hand("third_walk", 6, 0, 1'b0);
    ticks(5, 0);
    hand("back_ns", 0, 0, 1'b0);

    // Reset mid-phase.
    cyc(1'b0, 1'b1, 1'b0);
    ticks(22, 0);
    hand("ew_yel_cnt2", 4, 2, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    hand("mid_reset", 5, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    hand("reset_override", 5, 0, 1'b0);

    // Tick held high continuously.
    cyc(1'b1, 1'b0, 1'b0);
    hand("held_start", 0, 0, 1'b0);
    for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b0, 1'b0);
    hand("held_cnt7", 0, 7, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    hand("held_ns_yel", 1, 0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    hand("held_red_a", 2, 0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d left want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Phase sequencer for the Basys3 traffic-light design. It consumes the one-cycle timing strobe produced by the tick counter and steps a two-road intersection through green, yellow and all-red phases. It also inserts a pedestrian walk phase on request and drives the NS/EW lamp outputs and the walk indicator. It sits between the tick counter and the board LED/IO mapping.

## Interface
- GREEN_TICKS, 8, ticks spent in each green phase (>=1)
- YELLOW_TICKS, 3, ticks spent in each yellow phase (>=1)
- ALLRED_TICKS, 1, ticks spent in each all-red phase (>=1)
- WALK_TICKS, 5, ticks spent in the walk phase (>=1)
- CNT_WIDTH, 8, width of the phase tick counter; must hold max(duration)-1
- clk  input  1  system clock; one clock for the whole block
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- tick  input  1  timing strobe from the tick counter; each high cycle counts as one tick
- ped_req  input  1  pedestrian request, already debounced; any high cycle is latched
- ns_light  output  3  NS lamps {red,yellow,green}, one-hot
- ew_light  output  3  EW lamps {red,yellow,green}, one-hot
- walk  output  1  pedestrian walk lamp
- phase  output  3  current phase encoding
- phase_cnt  output  CNT_WIDTH  ticks elapsed in the current phase
- ped_pending  output  1  latched, unserved pedestrian request

## Operation
- Phases and encodings:
  - NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5, WALK=6.
  - Encoding 7 is illegal; it forces ALL_RED_B on the next clk.
- Sequence: NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> (WALK if ped_pending else NS_GREEN). WALK -> NS_GREEN.
- Phase advance:
  - On a cycle with tick=1 and phase_cnt == DUR(phase)-1, phase advances and phase_cnt clears to 0.
  - Otherwise, tick=1 increments phase_cnt.
  - tick=0 holds both phase and phase_cnt.
- Lamp decode:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - ALL_RED_A, ALL_RED_B and WALK: ns=100, ew=100.
  - walk=1 only in WALK.
  - Both roads are never green or yellow at the same time, under any input.
- Pedestrian latch:
  - ped_pending_next = (ped_pending & ~enter_walk) | ped_req.
  - enter_walk is the cycle on which phase goes ALL_RED_B -> WALK.
  - A ped_req high on the enter_walk cycle, or at any cycle during WALK, stays latched and is served on the following rotation.
- Reset values: phase=ALL_RED_B (5), phase_cnt=0, ped_pending=0, ns_light=100, ew_light=100, walk=0.

## Timing
- All outputs are registered and update on the same clk edge as phase; there are no combinational paths from inputs to outputs.
- Latency: the tick that completes a phase changes the lamps on that same clk edge, so the lamps change one clk after tick is sampled high.
- Phase length in clocks is DUR × (tick period); the full rotation without walk is 2×(GREEN+YELLOW+ALLRED) ticks, which is 24 with defaults.
- ped_req latency: a one-cycle pulse at any time sets ped_pending on the next edge.
- Reset:
  - Reset overrides tick and ped_req.
  - Reset asserted mid-phase returns the block to the reset values on the next edge.
  - The first phase after reset is ALL_RED_B, for ALLRED_TICKS ticks, then NS_GREEN (or WALK if ped_req arrived).
- phase_cnt never exceeds DUR-1, and it wraps only via the phase advance.

## Test plan
- Reset then idle: hold reset 2 clks, tick every 4 clks -> phase=5, lamps 100/100, walk=0; after 1 tick, phase=0 and ns=001.
- Full rotation with no request: 24 ticks from NS_GREEN -> phases 0(8 ticks), 1(3), 2(1), 3(8), 4(3), 5(1), then back to 0; never NS≠100 and EW≠100 together.
- Pedestrian served: 1-clk ped_req during EW_GREEN -> ped_pending=1; after ALL_RED_B, phase=6, walk=1, lamps 100/100 for 5 ticks; ped_pending=0 from WALK entry; then phase=0.
- Request during WALK: ped_req at tick 2 of WALK -> ped_pending stays 1; the next rotation enters WALK again after ALL_RED_B.
- Reset mid-phase: in EW_YELLOW with phase_cnt=2 and ped_pending=1, pulse reset -> next clk phase=5, phase_cnt=0, ped_pending=0, lamps 100/100.
- Tick held high continuously: NS_GREEN lasts exactly 8 clks, NS_YELLOW 3 clks; phase_cnt sequences 0..7 then 0.
